// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types, defaults and configuration limits for the FIFO read-side drain stage.
package fifo_rd_pkg;
  localparam int SKID_MIN = 2;
  localparam int DEF_SKID_DEPTH = 2;
  localparam int DEF_BURST_LEN = 4;
  typedef logic [$clog2(DEF_SKID_DEPTH+1)-1:0] occ_t;
  typedef logic [(DEF_BURST_LEN > 1 ? $clog2(DEF_BURST_LEN) : 1)-1:0] bidx_t;
  function automatic bit cfg_ok(input int skid_depth, input int burst_len);
    return skid_depth >= SKID_MIN && burst_len >= 1;
  endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: circular skid buffer absorbing the FIFO read latency; head entry is always presented.
module fifo_skid_buf #(
  parameter int DATA_W = 8,
  parameter int SKID_DEPTH = 2,
  localparam int OCC_W = $clog2(SKID_DEPTH+1),
  localparam int PTR_W = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [OCC_W-1:0]  occ_o
);
  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    head_d = pop_i ? nxt(head_q) : head_q;
    tail_d = push_i ? nxt(tail_q) : tail_q;
    occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
      if (push_i) mem_q[tail_q] <= data_i;
    end
  end

  assign head_o = mem_q[head_q];
  assign occ_o = occ_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a framed valid/ready stream,
// issuing reads only when the skid buffer is guaranteed room for the returning word.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  input  logic              fifo_empty_i,
  input  logic              fifo_rd_error_i,
  output logic              fifo_rd_en_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              err_o
);
  localparam int OCC_W = $clog2(SKID_DEPTH+1);
  localparam int SUM_W = OCC_W + 1;
  localparam int BIDX_W = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;

  if (!cfg_ok(SKID_DEPTH, BURST_LEN)) begin : g_cfg_err
    $error("fifo_rd_stream: SKID_DEPTH must be >= %0d and BURST_LEN >= 1", SKID_MIN);
  end

  logic [OCC_W-1:0] occ;
  logic inflight_q, pop, err_q, err_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fifo_skid_buf #(.DATA_W(DATA_W), .SKID_DEPTH(SKID_DEPTH)) u_skid (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (inflight_q),
    .data_i (fifo_rdata_i),
    .pop_i  (pop),
    .head_o (m_data_o),
    .occ_o  (occ)
  );

  // Room check counts the word already in flight, so a capture can never overflow the skid.
  always_comb begin
    m_valid_o = occ != '0;
    pop = m_valid_o && m_ready_i;
    fifo_rd_en_o = rst_n_i && !fifo_empty_i &&
                   (SUM_W'(occ) + SUM_W'(inflight_q) - SUM_W'(pop) < SUM_W'(SKID_DEPTH));
    bidx_d = !pop ? bidx_q : (bidx_q == BIDX_W'(BURST_LEN-1)) ? '0 : bidx_q + BIDX_W'(1);
    cnt_d = cnt_q + CNT_W'(pop);
    err_d = err_q || fifo_rd_error_i;
    m_last_o = m_valid_o && (bidx_q == BIDX_W'(BURST_LEN-1));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q <= 1'b0;
      bidx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en_o;
      bidx_q <= bidx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign word_cnt_o = cnt_q;
  assign err_o = err_q;
endmodule
